// File: rtl/alu_result_latch_if.sv
// Sequencer <-> result-latch bundle: request, operand bus and latched outputs.
// The sequencer side is the master; the latch itself is the slave.
interface alu_result_latch_if;
  logic       start;
  logic [2:0] func;
  logic       ld_cond;
  logic [7:0] b_in;
  logic [7:0] and_in;
  logic [7:0] or_in;
  logic [7:0] xor_in;
  logic [7:0] not_in;
  logic [7:0] sum_in;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_s;
  logic       flag_c;

  modport master (
    output start, func, ld_cond, b_in, and_in, or_in, xor_in, not_in, sum_in, carry_in,
    input  busy, done, result, flag_z, flag_s, flag_c
  );

  modport slave (
    input  start, func, ld_cond, b_in, and_in, or_in, xor_in, not_in, sum_in, carry_in,
    output busy, done, result, flag_z, flag_s, flag_c
  );
endinterface

// File: rtl/alu_result_latch.sv
// ALU result stage: on start, waits SETTLE_CYCLES for the relay outputs to settle,
// then latches the selected result and (optionally) the Z/S/C flags.
module alu_result_latch #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input logic               clk,
  input logic               reset_n,
  alu_result_latch_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETTLE = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_INC = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_NOT = 3'b101;
  localparam logic [2:0] F_SHL = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       func_q;
  logic             ld_q;
  logic [7:0]       sel;
  logic             carry_sel;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       result_q;
  logic             z_q;
  logic             s_q;
  logic             c_q;

  // Operand mux keyed on the func captured at start, never the live port.
  always_comb begin
    sel       = 8'h00;
    carry_sel = 1'b0;
    case (func_q)
      F_ADD, F_INC: begin
        sel       = bus.sum_in;
        carry_sel = bus.carry_in;
      end
      F_AND:   sel = bus.and_in;
      F_OR:    sel = bus.or_in;
      F_XOR:   sel = bus.xor_in;
      F_NOT:   sel = bus.not_in;
      F_SHL:   sel = {bus.b_in[6:0], bus.b_in[7]};
      default: sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      func_q   <= 3'b000;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      z_q      <= 1'b0;
      s_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            func_q <= bus.func;
            ld_q   <= bus.ld_cond;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result_q <= sel;
            if (ld_q) begin
              z_q <= (sel == 8'h00);
              s_q <= sel[7];
              c_q <= carry_sel;
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_z = z_q;
  assign bus.flag_s = s_q;
  assign bus.flag_c = c_q;
endmodule

// File: tb/tb_alu_result_latch.sv
// Scoreboard bench for alu_result_latch: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_result_latch;
  localparam int SETTLE = 4;

  typedef struct {
    logic [2:0] f;
    bit         ld;
    logic [7:0] b, a, o, x, n, s;
    bit         c;
  } op_t;

  typedef struct {
    logic [7:0] r;
    bit         z, s, c;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  alu_result_latch_if bus ();

  alu_result_latch #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mz = 0, ms = 0, mc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the spec says the latch holds after one operation.
  function automatic exp_t model(input op_t op);
    exp_t e;
    case (op.f)
      3'd0, 3'd1: e.r = op.s;
      3'd2:       e.r = op.a;
      3'd3:       e.r = op.o;
      3'd4:       e.r = op.x;
      3'd5:       e.r = op.n;
      3'd6:       e.r = (op.b << 1) | (op.b >> 7);
      default:    e.r = 8'h00;
    endcase
    if (op.ld) begin
      mz = (e.r == 8'h00);
      ms = e.r[7];
      mc = (op.f <= 3'd1) ? op.c : 1'b0;
    end
    e.z = mz; e.s = ms; e.c = mc;
    return e;
  endfunction

  function automatic op_t mk(input logic [2:0] f, input bit ld);
    op_t op;
    op.f = f; op.ld = ld;
    op.b = 8'($urandom); op.a = 8'($urandom); op.o = 8'($urandom);
    op.x = 8'($urandom); op.n = 8'($urandom); op.s = 8'($urandom);
    op.c = 1'($urandom);
    return op;
  endfunction

  task automatic drive_ops(input op_t op);
    bus.func = op.f; bus.ld_cond = op.ld;
    bus.b_in = op.b; bus.and_in = op.a; bus.or_in = op.o;
    bus.xor_in = op.x; bus.not_in = op.n; bus.sum_in = op.s; bus.carry_in = op.c;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_flags"}, {bus.flag_z, bus.flag_s, bus.flag_c}, 0);
  endtask

  // One operation; with disturb, start/func/operands are wiggled during SETTLE
  // and restored before the latch edge, and start is pulsed again in DONE.
  task automatic run_op(input op_t op, input bit disturb);
    bit got = 0;
    @(posedge clk); #1;
    drive_ops(op);
    bus.start = 1'b1;
    sb.push_back(model(op));
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= SETTLE + 3 && !got; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        check("done_latency", cyc, SETTLE + 1);
        check("busy_in_done", bus.busy, 0);
        got = 1;
        if (disturb) bus.start = 1'b1;
      end else begin
        check("busy_settle", bus.busy, 1);
        if (disturb) begin
          if (cyc == 1) begin
            bus.start = 1'b1; bus.func = ~op.f; bus.ld_cond = ~op.ld;
            bus.or_in = 8'($urandom); bus.sum_in = ~op.s;
          end
          if (cyc == 2) begin
            bus.start = 1'b0; bus.carry_in = ~op.c; bus.b_in = ~op.b;
          end
          if (cyc == 3) drive_ops(op);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", SETTLE + 3);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_done: got done pulse expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.r);
        check("flag_z", bus.flag_z, e.z);
        check("flag_s", bus.flag_s, e.s);
        check("flag_c", bus.flag_c, e.c);
      end
    end
  end

  initial begin
    op_t op;
    bus.start = 1'b0;
    drive_ops(mk(3'd0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_clear("reset");
    reset_n = 1'b1;

    op = mk(3'd2, 1); op.a = 8'h0F; run_op(op, 0);
    op = mk(3'd0, 1); op.s = 8'h00; op.c = 1; run_op(op, 0);
    op = mk(3'd5, 0); op.n = 8'h80; run_op(op, 0);
    op = mk(3'd6, 1); op.b = 8'hA5; run_op(op, 0);
    op = mk(3'd7, 1); run_op(op, 0);
    op = mk(3'd1, 1); op.s = 8'h9C; op.c = 1; run_op(op, 1);
    op = mk(3'd3, 1); op.o = 8'h3C; run_op(op, 1);

    // Reset in the second SETTLE cycle: clears at once, no done afterwards.
    @(posedge clk); #1;
    drive_ops(mk(3'd4, 1));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_clear("mid_reset");
    mz = 0; ms = 0; mc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < SETTLE + 4; i++) begin
      @(negedge clk);
      check("post_reset_idle", {bus.busy, bus.done}, 0);
    end
    op = mk(3'd4, 1); run_op(op, 0);

    for (int i = 0; i < 40; i++) begin
      op = mk(3'($urandom), 1'($urandom));
      run_op(op, 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
